// File: rtl/ledarray_rx.sv
// Receiver for the LED-array 2-wire serial link: decodes commands and fills a 16x8 display RAM.
// Latency: pin to decode SYNC_STAGES+1 cycles; write strobe one cycle after the 8th bit; read port 1 cycle.
// Backpressure: none; the link cannot be stalled, every decoded event is acted on immediately.
//
// Ports:
//   CLK, i_reset            system clock and synchronous active-high reset
//   i_sclk, i_sdin          asynchronous serial pins (idle high, LSB first)
//   i_rd_addr / o_rd_data   registered display RAM read port
//   o_wr_valid/addr/data    one-cycle pulse describing each RAM write
//   o_disp_on, o_brightness display-control state
//   o_auto_inc              address pointer mode (1 = increment after each write)
//   o_frame_err             one-cycle pulse on any malformed or dropped byte
module ledarray_rx #(
  parameter int SYNC_STAGES      = 2,
  parameter bit DEFAULT_AUTO_INC = 1'b1
) (
  input  logic       CLK,
  input  logic       i_reset,
  input  logic       i_sclk,
  input  logic       i_sdin,
  input  logic [3:0] i_rd_addr,
  output logic [7:0] o_rd_data,
  output logic       o_wr_valid,
  output logic [3:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_disp_on,
  output logic [2:0] o_brightness,
  output logic       o_auto_inc,
  output logic       o_frame_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_DISCARD
  } state_e;

  // ---------------------------------------------------------------------------
  // Pin synchronisers and edge history.
  // Synchronisers clear to 0 so that after reset both lines rise together with
  // sclk, which can only ever look like a BIT (ignored in IDLE) and never like a
  // spurious START/STOP.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] sdin_sync_q;
  logic                   sclk_prev_q;
  logic                   sdin_prev_q;

  always_ff @(posedge CLK) begin
    if (i_reset) begin
      sclk_sync_q <= '0;
      sdin_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      sdin_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
      sdin_sync_q <= {sdin_sync_q[SYNC_STAGES-2:0], i_sdin};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      sdin_prev_q <= sdin_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s;
  logic sdin_s;
  logic sclk_hi_stable;
  logic bit_ev;
  logic start_ev;
  logic stop_ev;

  assign sclk_s         = sclk_sync_q[SYNC_STAGES-1];
  assign sdin_s         = sdin_sync_q[SYNC_STAGES-1];
  // A rising sclk means sclk_prev_q is low, so a simultaneous sdin change can
  // never qualify as START/STOP: it is taken as a BIT with the new sdin.
  assign sclk_hi_stable = sclk_s & sclk_prev_q;
  assign bit_ev         = sclk_s & ~sclk_prev_q;
  assign start_ev       = sclk_hi_stable & sdin_prev_q & ~sdin_s;
  assign stop_ev        = sclk_hi_stable & ~sdin_prev_q & sdin_s;

  // ---------------------------------------------------------------------------
  // Frame decoder state
  // ---------------------------------------------------------------------------
  state_e      state_q,     state_d;
  logic [2:0]  bitcnt_q,    bitcnt_d;
  logic [7:0]  shift_q,     shift_d;
  logic [3:0]  ptr_q,       ptr_d;
  logic        auto_inc_q,  auto_inc_d;
  logic        disp_on_q,   disp_on_d;
  logic [2:0]  bright_q,    bright_d;
  logic        wr_valid_q,  wr_valid_d;
  logic [3:0]  wr_addr_q,   wr_addr_d;
  logic [7:0]  wr_data_q,   wr_data_d;
  logic        frame_err_q, frame_err_d;
  logic        ram_we;

  logic [7:0]  ram_q [16];
  logic [7:0]  rd_data_q;

  always_ff @(posedge CLK) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      ptr_q       <= 4'd0;
      auto_inc_q  <= DEFAULT_AUTO_INC;
      disp_on_q   <= 1'b0;
      bright_q    <= 3'd0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= 4'd0;
      wr_data_q   <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      auto_inc_q  <= auto_inc_d;
      disp_on_q   <= disp_on_d;
      bright_q    <= bright_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    auto_inc_d  = auto_inc_q;
    disp_on_d   = disp_on_q;
    bright_d    = bright_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    ram_we      = 1'b0;

    if (state_q == S_IDLE) begin
      // Only a START opens a frame; stray bits and stops are ignored.
      if (start_ev) begin
        state_d  = S_CMD;
        bitcnt_d = 3'd0;
      end
    end else if (start_ev) begin
      // Repeated start aborts the current frame.
      frame_err_d = (bitcnt_q != 3'd0);
      state_d     = S_CMD;
      bitcnt_d    = 3'd0;
    end else if (stop_ev) begin
      frame_err_d = (bitcnt_q != 3'd0);
      state_d     = S_IDLE;
      bitcnt_d    = 3'd0;
    end else if (bit_ev) begin
      shift_d[bitcnt_q] = sdin_s;
      // 3-bit counter wraps 7 -> 0, which is exactly the byte boundary.
      bitcnt_d = bitcnt_q + 3'd1;
      if (bitcnt_q == 3'd7) begin
        case (state_q)
          S_CMD: begin
            case (shift_d[7:6])
              2'b01: begin
                auto_inc_d = ~shift_d[2];
                state_d    = S_DISCARD;
              end
              2'b10: begin
                disp_on_d = shift_d[3];
                bright_d  = shift_d[2:0];
                state_d   = S_DISCARD;
              end
              2'b11: begin
                ptr_d   = shift_d[3:0];
                state_d = S_DATA;
              end
              default: begin
                frame_err_d = 1'b1;
                state_d     = S_DISCARD;
              end
            endcase
          end
          S_DATA: begin
            ram_we     = 1'b1;
            wr_valid_d = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = shift_d;
            if (auto_inc_q) begin
              ptr_d = ptr_q + 4'd1;
            end
          end
          S_DISCARD: begin
            frame_err_d = 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display RAM: write from the decoder, registered read. A read of the cell
  // being written in the same cycle returns the previous contents.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (i_reset) begin
      for (int i = 0; i < 16; i++) begin
        ram_q[i] <= 8'h00;
      end
    end else if (ram_we) begin
      ram_q[wr_addr_d] <= wr_data_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (i_reset) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= ram_q[i_rd_addr];
    end
  end

  assign o_rd_data    = rd_data_q;
  assign o_wr_valid   = wr_valid_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_disp_on    = disp_on_q;
  assign o_brightness = bright_q;
  assign o_auto_inc   = auto_inc_q;
  assign o_frame_err  = frame_err_q;

endmodule

// File: tb/tb_ledarray_rx.sv
// Bench for ledarray_rx: drives framed serial traffic on the pins and checks
// display state, write strobes, frame errors and RAM contents against a
// frame-level model of the command set.
module tb_ledarray_rx;

  logic       CLK = 1'b0;
  logic       i_reset;
  logic       i_sclk;
  logic       i_sdin;
  logic [3:0] i_rd_addr;
  logic [7:0] o_rd_data;
  logic       o_wr_valid;
  logic [3:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic       o_disp_on;
  logic [2:0] o_brightness;
  logic       o_auto_inc;
  logic       o_frame_err;

  always #5 CLK = ~CLK;

  ledarray_rx #(
    .SYNC_STAGES      (2),
    .DEFAULT_AUTO_INC (1'b1)
  ) dut (
    .CLK          (CLK),
    .i_reset      (i_reset),
    .i_sclk       (i_sclk),
    .i_sdin       (i_sdin),
    .i_rd_addr    (i_rd_addr),
    .o_rd_data    (o_rd_data),
    .o_wr_valid   (o_wr_valid),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_disp_on    (o_disp_on),
    .o_brightness (o_brightness),
    .o_auto_inc   (o_auto_inc),
    .o_frame_err  (o_frame_err)
  );

  int compared   = 0;
  int mismatched = 0;

  // Observed write strobes and frame-error pulses.
  logic [11:0] obs_q [$];
  int          err_seen = 0;

  always @(negedge CLK) begin
    if (i_reset === 1'b0) begin
      if (o_wr_valid === 1'b1) obs_q.push_back({o_wr_addr, o_wr_data});
      if (o_frame_err === 1'b1) err_seen++;
    end
  end

  // Frame-level reference model.
  logic [7:0]  m_ram [16];
  logic [3:0]  m_ptr;
  logic        m_auto;
  logic        m_disp;
  logic [2:0]  m_bright;
  logic [7:0]  tx_q  [$];
  logic [11:0] exp_w [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
    m_ptr    = 4'd0;
    m_auto   = 1'b1;
    m_disp   = 1'b0;
    m_bright = 3'd0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    wait_n(2);
    i_reset = 1'b0;
    model_reset();
  endtask

  // Bus idles with both lines high; START pulls sdin low under a high sclk.
  task automatic do_start();
    i_sdin = 1'b0;
    wait_n(4);
  endtask

  // Each bit: sclk low, present data, sclk high (sampled on the rising edge).
  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      i_sclk = 1'b0;
      wait_n(4);
      i_sdin = b[i];
      wait_n(4);
      i_sclk = 1'b1;
      wait_n(4);
    end
  endtask

  // sclk is high after the last bit. If sdin is high it cannot rise, so it is
  // first dropped (a repeated start at a byte boundary has no side effects)
  // and then raised for the STOP.
  task automatic do_stop();
    if (i_sdin) begin
      i_sdin = 1'b0;
      wait_n(4);
    end
    i_sdin = 1'b1;
    wait_n(4);
  endtask

  // Sends tx_q as one frame (command first) plus 'partial' trailing bits,
  // then compares against the model's prediction for that frame.
  task automatic run_frame(input string tag, input int partial);
    int         base_w;
    int         base_e;
    int         exp_e;
    logic [7:0] c;
    base_w = obs_q.size();
    base_e = err_seen;
    exp_e  = 0;
    exp_w.delete();
    c = tx_q[0];
    case (c[7:6])
      2'b01:   m_auto = ~c[2];
      2'b10:   begin m_disp = c[3]; m_bright = c[2:0]; end
      2'b11:   m_ptr = c[3:0];
      default: exp_e++;
    endcase
    for (int i = 1; i < tx_q.size(); i++) begin
      if (c[7:6] == 2'b11) begin
        m_ram[m_ptr] = tx_q[i];
        exp_w.push_back({m_ptr, tx_q[i]});
        if (m_auto) m_ptr = m_ptr + 4'd1;
      end else begin
        exp_e++;
      end
    end
    if (partial > 0) exp_e++;

    do_start();
    foreach (tx_q[i]) send_bits(tx_q[i], 8);
    if (partial > 0) send_bits(8'($urandom), partial);
    do_stop();
    wait_n(12);

    check({tag, ".wr_count"}, 32'(obs_q.size() - base_w), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++) begin
      if (base_w + i < obs_q.size())
        check({tag, ".wr_entry"}, 32'(obs_q[base_w + i]), 32'(exp_w[i]));
    end
    check({tag, ".frame_err"}, 32'(err_seen - base_e), 32'(exp_e));
    check({tag, ".disp_on"},   32'(o_disp_on),    32'(m_disp));
    check({tag, ".bright"},    32'(o_brightness), 32'(m_bright));
    check({tag, ".auto_inc"},  32'(o_auto_inc),   32'(m_auto));
  endtask

  task automatic readback(input string tag);
    for (int a = 0; a < 16; a++) begin
      i_rd_addr = 4'(a);
      @(negedge CLK);
      check(tag, 32'(o_rd_data), 32'(m_ram[a]));
    end
  endtask

  initial begin
    int base_w;
    int base_e;
    int nd;
    int part;
    logic [7:0] c;

    i_reset   = 1'b1;
    i_sclk    = 1'b1;
    i_sdin    = 1'b1;
    i_rd_addr = 4'd0;
    @(negedge CLK);

    // Reset state
    do_reset();
    check("rst.disp_on",   32'(o_disp_on),    32'd0);
    check("rst.bright",    32'(o_brightness), 32'd0);
    check("rst.auto_inc",  32'(o_auto_inc),   32'd1);
    check("rst.wr_valid",  32'(o_wr_valid),   32'd0);
    check("rst.frame_err", 32'(o_frame_err),  32'd0);
    check("rst.rd_data",   32'(o_rd_data),    32'd0);
    wait_n(4);
    readback("rst.ram");

    // Display control
    tx_q = '{8'h89};
    run_frame("dispctl", 0);

    // Address set with two writes, then a one-cycle read of address 1
    tx_q = '{8'hC0, 8'h06, 8'h5B};
    run_frame("write2", 0);
    i_rd_addr = 4'd0;
    @(negedge CLK);
    i_rd_addr = 4'd1;
    @(negedge CLK);
    check("rd_latency", 32'(o_rd_data), 32'h5B);

    // Fixed-address mode
    tx_q = '{8'h44};
    run_frame("fixed_mode", 0);
    tx_q = '{8'hC3, 8'hAA, 8'hBB};
    run_frame("fixed_wr", 0);

    // Increment mode with 15 -> 0 wrap
    tx_q = '{8'h40};
    run_frame("inc_mode", 0);
    tx_q = '{8'hCF, 8'h11, 8'h22, 8'h33};
    run_frame("wrap_wr", 0);
    readback("ram_a");

    // Truncated data byte
    tx_q = '{8'hC2};
    run_frame("partial", 5);

    // Reset in the middle of a data byte; the rest of that frame is ignored
    base_w = obs_q.size();
    base_e = err_seen;
    do_start();
    send_bits(8'hC2, 8);
    send_bits(8'h5A, 3);
    do_reset();
    send_bits(8'hFF, 5);
    do_stop();
    wait_n(12);
    check("midrst.wr_count", 32'(obs_q.size() - base_w), 32'd0);
    check("midrst.err",      32'(err_seen - base_e),     32'd0);
    check("midrst.auto_inc", 32'(o_auto_inc),            32'd1);
    check("midrst.disp_on",  32'(o_disp_on),             32'd0);
    tx_q = '{8'hC0, 8'h06, 8'h5B};
    run_frame("after_rst", 0);
    readback("ram_b");

    // Randomized frames
    for (int n = 0; n < 30; n++) begin
      c      = 8'($urandom);
      c[7:6] = 2'($urandom_range(0, 3));
      nd     = $urandom_range(0, 3);
      part   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      tx_q.delete();
      tx_q.push_back(c);
      for (int k = 0; k < nd; k++) tx_q.push_back(8'($urandom));
      run_frame("rand", part);
    end
    readback("ram_rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
